// File: rtl/dcache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller_pkg
// Description : Shared types and address-field constants for the data cache.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_controller_pkg;

    localparam int OFF_W  = 2;
    localparam int BYTE_W = 8;
    localparam int BLK_W  = 32;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_IDX_W  = 3;
    localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/dcache_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dcache_fsm
// Description : Miss sequencer: dirty write-back then block fetch, with
//               registered memory request outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_fsm
    import dcache_controller_pkg::*;
#(
    parameter int BLK_AW = 6,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_hit,
    input  logic              i_victim_dirty,
    input  logic [BLK_AW-1:0] i_req_blk_addr,
    input  logic [BLK_AW-1:0] i_victim_blk_addr,
    input  logic [BLK_W-1:0]  i_victim_data,
    input  logic              i_mem_busywait,
    output state_e            o_state,
    output logic              o_fill_en,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [BLK_AW-1:0] o_mem_address,
    output logic [BLK_W-1:0]  o_mem_writedata
);

    state_e              state_q, state_d;
    logic                issued_q, issued_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [BLK_AW-1:0]   mem_address_q, mem_address_d;
    logic [BLK_W-1:0]    mem_writedata_q, mem_writedata_d;
    logic                w_xfer_done;
    logic                w_same_line;

    always_comb begin
        state_d         = state_q;
        issued_d        = issued_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        o_fill_en       = 1'b0;
        // issued is only set from the entry edge on, so the entry edge never completes
        w_xfer_done     = issued_q && !i_mem_busywait;
        w_same_line     = (i_req_blk_addr[IDX_W-1:0] == i_victim_blk_addr[IDX_W-1:0]);

        case (state_q)
            IDLE: begin
                if (i_req && !i_hit) begin
                    issued_d = 1'b1;
                    if (i_victim_dirty) begin
                        state_d         = WRITEBACK;
                        mem_write_d     = 1'b1;
                        mem_address_d   = i_victim_blk_addr;
                        mem_writedata_d = i_victim_data;
                    end else begin
                        state_d       = FETCH;
                        mem_read_d    = 1'b1;
                        mem_address_d = i_req_blk_addr;
                    end
                end
            end
            WRITEBACK: begin
                if (w_xfer_done) begin
                    mem_write_d     = 1'b0;
                    mem_writedata_d = '0;
                    // a dropped or retargeted request falls back to IDLE to be re-evaluated
                    if (i_req && !i_hit && w_same_line) begin
                        state_d       = FETCH;
                        mem_read_d    = 1'b1;
                        mem_address_d = i_req_blk_addr;
                    end else begin
                        state_d       = IDLE;
                        issued_d      = 1'b0;
                        mem_address_d = '0;
                    end
                end
            end
            FETCH: begin
                if (w_xfer_done) begin
                    o_fill_en     = 1'b1;
                    state_d       = IDLE;
                    issued_d      = 1'b0;
                    mem_read_d    = 1'b0;
                    mem_address_d = '0;
                end
            end
            default: begin
                state_d         = IDLE;
                issued_d        = 1'b0;
                mem_read_d      = 1'b0;
                mem_write_d     = 1'b0;
                mem_address_d   = '0;
                mem_writedata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            issued_q        <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            issued_q        <= issued_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign o_state         = state_q;
    assign o_mem_read      = mem_read_q;
    assign o_mem_write     = mem_write_q;
    assign o_mem_address   = mem_address_q;
    assign o_mem_writedata = mem_writedata_q;

endmodule
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
// Module      : dcache_controller
// Description : Direct-mapped write-back data cache, byte cpu port and
//               32-bit block memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    READ,
    input  logic                    WRITE,
    input  logic [ADDR_W-1:0]       ADDRESS,
    input  logic [BYTE_W-1:0]       WRITEDATA,
    output logic [BYTE_W-1:0]       READDATA,
    output logic                    BUSYWAIT,
    output logic                    MEM_READ,
    output logic                    MEM_WRITE,
    output logic [ADDR_W-OFF_W-1:0] MEM_ADDRESS,
    output logic [BLK_W-1:0]        MEM_WRITEDATA,
    input  logic [BLK_W-1:0]        MEM_READDATA,
    input  logic                    MEM_BUSYWAIT
);

    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int LINES  = 2 ** IDX_W;
    localparam int BLK_AW = ADDR_W - OFF_W;

    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [BLK_W-1:0] data_q [LINES];
    logic [BLK_W-1:0] data_d [LINES];

    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_off;
    logic             w_req;
    logic             w_hit;
    logic             w_fill_en;
    logic [IDX_W-1:0] w_fill_idx;
    logic [TAG_W-1:0] w_fill_tag;
    state_e           w_state;

    assign w_tag = ADDRESS[ADDR_W-1 -: TAG_W];
    assign w_idx = ADDRESS[OFF_W +: IDX_W];
    assign w_off = ADDRESS[OFF_W-1:0];
    assign w_req = READ | WRITE;
    assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == w_tag);

    assign BUSYWAIT = w_req && (!w_hit || (w_state != IDLE));
    assign READDATA = data_q[w_idx][{w_off, 3'b000} +: BYTE_W];

    // The fill target comes from the registered block address, not the live cpu address
    assign w_fill_idx = MEM_ADDRESS[IDX_W-1:0];
    assign w_fill_tag = MEM_ADDRESS[BLK_AW-1 -: TAG_W];

    dcache_fsm #(
        .BLK_AW (BLK_AW),
        .IDX_W  (IDX_W)
    ) u_fsm (
        .clk               (CLK),
        .rst               (RESET),
        .i_req             (w_req),
        .i_hit             (w_hit),
        .i_victim_dirty    (valid_q[w_idx] && dirty_q[w_idx]),
        .i_req_blk_addr    (ADDRESS[ADDR_W-1:OFF_W]),
        .i_victim_blk_addr ({tag_q[w_idx], w_idx}),
        .i_victim_data     (data_q[w_idx]),
        .i_mem_busywait    (MEM_BUSYWAIT),
        .o_state           (w_state),
        .o_fill_en         (w_fill_en),
        .o_mem_read        (MEM_READ),
        .o_mem_write       (MEM_WRITE),
        .o_mem_address     (MEM_ADDRESS),
        .o_mem_writedata   (MEM_WRITEDATA)
    );

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (w_fill_en) begin
            valid_d[w_fill_idx] = 1'b1;
            dirty_d[w_fill_idx] = 1'b0;
            tag_d[w_fill_idx]   = w_fill_tag;
            data_d[w_fill_idx]  = MEM_READDATA;
        end else if (WRITE && !BUSYWAIT) begin
            data_d[w_idx][{w_off, 3'b000} +: BYTE_W] = WRITEDATA;
            dirty_d[w_idx] = 1'b1;
        end
    end

    // Tag and data arrays hold their contents through reset; only the state bits clear
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

endmodule
`default_nettype wire
